global_buffer_arbiter: RTL

Shares the single global-buffer SRAM port between up to NUM_REQ requesters: instruction scheduler, DMA engine, PE-array writeback, auxiliary units. Arbitration is round-robin with burst locking. Memory-side signals are registered. Read data returns to the owning requester with fixed latency. The block sits between the control/DMA layer and the global buffer macro, replacing direct point-to-point drive of `global_buffer_*`.

---
 rtl/global_buffer_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/global_buffer_arbiter.sv
// Round-robin, burst-locking arbiter that shares the single global-buffer SRAM port
// between NUM_REQ requesters, with registered memory drive and in-order read return.
module global_buffer_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         gb_addr,
    output logic [DATA_W-1:0]         gb_wdata,
    output logic                      gb_we,
    output logic                      gb_ce,
    input  logic [DATA_W-1:0]         gb_rdata,
    output logic [2:0]                grant_id,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         last_grant;
    logic [2:0]         winner;
    logic               found;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   beat_nxt;
    logic               accept;
    logic               burst_end;

    logic               sel_valid;
    logic               sel_we;
    logic               sel_last;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    logic               s1_rd, s2_rd;
    logic [2:0]         s1_own, s2_own;

    // Round-robin search starting just after the previous owner, wrapping upward.
    always_comb begin
        logic [7:0]  vld8;
        int unsigned idx;
        winner = '0;
        found  = 1'b0;
        vld8   = 8'(req_valid);
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_grant) + k) % NUM_REQ;
            if (!found && vld8[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_we    = 1'b0;
        sel_last  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == BURST) && (grant_id == 3'(i));
            if (grant_id == 3'(i)) begin
                sel_valid = req_valid[i];
                sel_we    = req_we[i];
                sel_last  = req_last[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept    = (state == BURST) && sel_valid;
    assign beat_nxt  = beat_cnt + 1'b1;
    assign burst_end = accept && (sel_last || (beat_nxt == CNT_W'(MAX_BURST)));
    assign busy      = (state == BURST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = BURST;
            BURST:   if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id   <= '0;
            last_grant <= 3'(NUM_REQ - 1);
            beat_cnt   <= '0;
            gb_addr    <= '0;
            gb_wdata   <= '0;
            gb_we      <= 1'b0;
            gb_ce      <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                grant_id <= winner;
                beat_cnt <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_nxt;
                gb_addr  <= sel_addr;
                gb_wdata <= sel_wdata;
                gb_we    <= sel_we;
                gb_ce    <= 1'b1;
            end else begin
                gb_we    <= 1'b0;
                gb_ce    <= 1'b0;
            end
            if (burst_end) last_grant <= grant_id;
        end
    end

    // s1 is aligned with gb_ce, s2 with gb_rdata; the response register then
    // captures the data, giving accept edge + 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rd     <= 1'b0;
            s1_own    <= '0;
            s2_rd     <= 1'b0;
            s2_own    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            s1_rd  <= accept && !sel_we;
            s1_own <= grant_id;
            s2_rd  <= s1_rd;
            s2_own <= s1_own;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                rsp_valid[i] <= s2_rd && (s2_own == 3'(i));
            end
            if (s2_rd) rsp_rdata <= gb_rdata;
        end
    end

endmodule
